// File: rtl/pal_cfg_loader.sv
// Serializes a byte-stream configuration image MSB-first onto the PAL config chain.
// Define PAL_CFG_CRC_EN to build the CRC-8 over the shifted bits; otherwise CRC_OUT is 0.
module pal_cfg_loader #(
   parameter int SR_LEN  = 27,
   parameter int CLK_DIV = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       START,
   input  logic [7:0] IN_DATA,
   input  logic       IN_VALID,
   output logic       IN_READY,
   output logic       CFG,
   output logic       CFG_CLK,
   output logic       BUSY,
   output logic       DONE,
   output logic [7:0] CRC_OUT
);
   localparam int NB = (SR_LEN + 7) / 8;
   localparam int BW = $clog2(SR_LEN + 1);
   localparam int AW = $clog2(NB + 1);
   localparam int PW = $clog2(CLK_DIV);
   localparam int HI = CLK_DIV / 2;

   typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

   state_t        state;
   logic [BW-1:0] bit_cnt;
   logic [AW-1:0] acc_cnt;
   logic [PW-1:0] ph;
   logic          running;
   logic [7:0]    act;
   logic [3:0]    act_cnt;
   logic [7:0]    hold;
   logic          hold_full;

   logic          accept;
   logic          slot_end;
   logic          last_slot;
   logic          slot_start;
   logic          pop;
   logic          pop_bit;
   logic [AW-1:0] acc_cnt_nx;
   logic [7:0]    act_nx;
   logic [3:0]    act_cnt_nx;
   logic [7:0]    hold_nx;
   logic          hold_full_nx;

   // Buffer update order: take incoming byte, pop a bit at slot start, then refill
   // the active byte from the holding register so a byte boundary costs no slot.
   always_comb begin
      accept       = IN_VALID & IN_READY;
      slot_end     = running && (ph == PW'(CLK_DIV - 1));
      last_slot    = slot_end && (bit_cnt == BW'(SR_LEN - 1));
      slot_start   = (state == LOAD) && (!running || slot_end) && !last_slot;
      acc_cnt_nx   = (accept && (acc_cnt != AW'(NB))) ? acc_cnt + AW'(1) : acc_cnt;
      act_nx       = act;
      act_cnt_nx   = act_cnt;
      hold_nx      = hold;
      hold_full_nx = hold_full;
      if (accept) begin
         if (act_cnt == 4'd0) begin
            act_nx     = IN_DATA;
            act_cnt_nx = 4'd8;
         end else begin
            hold_nx      = IN_DATA;
            hold_full_nx = 1'b1;
         end
      end
      pop     = slot_start && (act_cnt_nx != 4'd0);
      pop_bit = act_nx[7];
      if (pop) begin
         act_nx     = {act_nx[6:0], 1'b0};
         act_cnt_nx = act_cnt_nx - 4'd1;
      end
      if ((act_cnt_nx == 4'd0) && hold_full_nx) begin
         act_nx       = hold_nx;
         act_cnt_nx   = 4'd8;
         hold_full_nx = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         acc_cnt   <= '0;
         ph        <= '0;
         running   <= 1'b0;
         act       <= '0;
         act_cnt   <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         IN_READY  <= 1'b0;
         CFG       <= 1'b0;
         CFG_CLK   <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               DONE     <= 1'b0;
               CFG      <= 1'b0;
               CFG_CLK  <= 1'b0;
               IN_READY <= 1'b0;
               if (START) begin
                  state     <= LOAD;
                  BUSY      <= 1'b1;
                  IN_READY  <= 1'b1;
                  bit_cnt   <= '0;
                  acc_cnt   <= '0;
                  ph        <= '0;
                  running   <= 1'b0;
                  act_cnt   <= '0;
                  hold_full <= 1'b0;
               end
            end
            LOAD: begin
               acc_cnt   <= acc_cnt_nx;
               act       <= act_nx;
               act_cnt   <= act_cnt_nx;
               hold      <= hold_nx;
               hold_full <= hold_full_nx;
               if (slot_end) bit_cnt <= bit_cnt + BW'(1);
               if (last_slot) begin
                  state    <= FIN;
                  BUSY     <= 1'b0;
                  DONE     <= 1'b1;
                  IN_READY <= 1'b0;
                  CFG_CLK  <= 1'b0;
                  running  <= 1'b0;
               end else begin
                  IN_READY <= !hold_full_nx && (acc_cnt_nx != AW'(NB));
                  if (running && !slot_end) begin
                     ph      <= ph + PW'(1);
                     CFG_CLK <= ((int'(ph) + 1) >= (CLK_DIV - HI));
                  end else if (pop) begin
                     running <= 1'b1;
                     ph      <= '0;
                     CFG     <= pop_bit;
                     CFG_CLK <= 1'b0;
                  end else begin
                     // Starved: hold CFG, no strobe, slot does not advance.
                     running <= 1'b0;
                     CFG_CLK <= 1'b0;
                  end
               end
            end
            FIN: begin
               DONE  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PAL_CFG_CRC_EN
   logic [7:0] crc;
   logic [7:0] crc_nx;

   // CRC-8 poly 0x07, fed the bit that was on CFG during the slot just completed.
   always_comb crc_nx = {crc[6:0], 1'b0} ^ (((crc[7] ^ CFG) != 1'b0) ? 8'h07 : 8'h00);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         crc     <= 8'h00;
         CRC_OUT <= 8'h00;
      end else if ((state == IDLE) && START) begin
         crc     <= 8'h00;
         CRC_OUT <= 8'h00;
      end else if (slot_end) begin
         crc <= crc_nx;
         if (last_slot) CRC_OUT <= crc_nx;
      end
   end
`else
   assign CRC_OUT = 8'h00;
`endif

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Self-checking bench for pal_cfg_loader: default instance plus an SR_LEN=8/CLK_DIV=5 instance.
module tb_pal_cfg_loader;
   logic            CLK = 1'b0;
   logic            RST_N;
   logic [1:0]      start;
   logic [1:0]      in_valid;
   logic [1:0][7:0] in_data;
   wire  [1:0]      in_ready;
   wire  [1:0]      cfg;
   wire  [1:0]      cfg_clk;
   wire  [1:0]      busy;
   wire  [1:0]      done;
   wire  [1:0][7:0] crc_out;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   pal_cfg_loader u0 (
      .CLK(CLK), .RST_N(RST_N), .START(start[0]), .IN_DATA(in_data[0]), .IN_VALID(in_valid[0]),
      .IN_READY(in_ready[0]), .CFG(cfg[0]), .CFG_CLK(cfg_clk[0]), .BUSY(busy[0]), .DONE(done[0]),
      .CRC_OUT(crc_out[0])
   );

   pal_cfg_loader #(.SR_LEN(8), .CLK_DIV(5)) u1 (
      .CLK(CLK), .RST_N(RST_N), .START(start[1]), .IN_DATA(in_data[1]), .IN_VALID(in_valid[1]),
      .IN_READY(in_ready[1]), .CFG(cfg[1]), .CFG_CLK(cfg_clk[1]), .BUSY(busy[1]), .DONE(done[1]),
      .CRC_OUT(crc_out[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One load on instance sel. The image is the stream MSB-first: stream bit k is img[31-k].
   // IN_VALID is dropped for gap_len cycles before byte gap_idx; excess bytes are offered as 0x55.
   task automatic run_load(input int sel, input logic [31:0] img, input int gap_idx,
                           input int gap_len, input int restart_at, input int rst_after,
                           input string tag);
      int sr, dv, h, nb, n, idx, acc, rises, run, wait_cnt, done_n, shape;
      logic pend, prev_clk, prev_cfg, seen;
      logic [31:0] obs;
      logic [7:0] crc_exp, crc_at_done;
      sr = (sel == 0) ? 27 : 8;
      dv = (sel == 0) ? 2 : 5;
      h  = dv / 2;
      nb = (sr + 7) / 8;
      crc_exp = 8'h00;
`ifdef PAL_CFG_CRC_EN
      for (int k = 0; k < sr; k++)
         crc_exp = {crc_exp[6:0], 1'b0} ^ (((crc_exp[7] ^ img[31-k]) != 1'b0) ? 8'h07 : 8'h00);
`endif
      idx = 0; acc = 0; rises = 0; run = 0; shape = 0; obs = '0; done_n = 0;
      pend = 1'b0; seen = 1'b0; crc_at_done = 8'h00;
      wait_cnt = (gap_idx == 0) ? gap_len : 0;

      @(negedge CLK);
      start[sel]    = 1'b1;
      in_valid[sel] = 1'b1;
      in_data[sel]  = 8'h55;
      prev_clk      = cfg_clk[sel];
      prev_cfg      = cfg[sel];
      @(negedge CLK);
      start[sel] = 1'b0;
      check({tag, "/busy_after_start"}, busy[sel], 1);
      check({tag, "/ready_after_start"}, in_ready[sel], 1);

      n = 1;
      while (!seen && n < 800) begin
         if (pend) begin
            acc++;
            idx++;
            if (idx == gap_idx) wait_cnt = gap_len;
         end
         if (cfg_clk[sel] && (cfg[sel] !== prev_cfg)) shape++;
         if (cfg_clk[sel] && !prev_clk) begin
            rises++;
            obs = {obs[30:0], cfg[sel]};
            run = 0;
         end
         if (cfg_clk[sel]) run++;
         else if (prev_clk && run != h) shape++;
         if (gap_idx == 0 && n <= gap_len + 1 && cfg_clk[sel]) shape++;
         if (done[sel]) begin
            seen        = 1'b1;
            done_n      = n;
            crc_at_done = crc_out[sel];
            check({tag, "/busy_at_done"}, busy[sel], 0);
            check({tag, "/ready_at_done"}, in_ready[sel], 0);
            check({tag, "/crc_at_done"}, crc_out[sel], crc_exp);
         end
         if (rst_after > 0 && rises == rst_after && prev_clk && !cfg_clk[sel]) begin
            #2 RST_N = 1'b0;
            #1 check({tag, "/async_reset_outputs"},
                     {in_ready[sel], cfg[sel], cfg_clk[sel], busy[sel], done[sel], crc_out[sel]}, 0);
            in_valid[sel] = 1'b0;
            start[sel]    = 1'b0;
            repeat (2) @(negedge CLK);
            RST_N = 1'b1;
            @(negedge CLK);
            return;
         end
         start[sel] = (n == restart_at);
         if (wait_cnt > 0) begin
            in_valid[sel] = 1'b0;
            wait_cnt--;
         end else begin
            in_valid[sel] = 1'b1;
            in_data[sel]  = (idx < nb) ? 8'(img >> (24 - 8 * idx)) : 8'h55;
         end
         pend     = in_valid[sel] && in_ready[sel];
         prev_clk = cfg_clk[sel];
         prev_cfg = cfg[sel];
         if (!seen) begin
            @(negedge CLK);
            n++;
         end
      end
      start[sel] = 1'b0;
      check({tag, "/done_seen"}, seen, 1);
      @(negedge CLK);
      check({tag, "/done_one_cycle"}, done[sel], 0);
      check({tag, "/crc_held"}, crc_out[sel], crc_at_done);
      check({tag, "/idle_ready"}, in_ready[sel], 0);
      in_valid[sel] = 1'b0;
      check({tag, "/pulses"}, rises, sr);
      check({tag, "/bits"}, obs, img >> (32 - sr));
      check({tag, "/bytes_taken"}, acc, nb);
      check({tag, "/strobe_shape"}, shape, 0);
      if (gap_len == 0 || gap_idx == 0)
         check({tag, "/latency"}, done_n, sr * dv + 2 + ((gap_idx == 0) ? gap_len : 0));
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      start    = '0;
      in_valid = '0;
      in_data  = '0;
      RST_N    = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_in_ready", in_ready[0], 0);
      check("rst_cfg", cfg[0], 0);
      check("rst_cfg_clk", cfg_clk[0], 0);
      check("rst_busy", busy[0], 0);
      check("rst_done", done[0], 0);
      check("rst_crc", crc_out[0], 0);
      check("rst_u1", {in_ready[1], cfg[1], cfg_clk[1], busy[1], done[1], crc_out[1]}, 0);
      RST_N = 1'b1;
      @(negedge CLK);

      in_valid[0] = 1'b1;
      in_data[0]  = 8'hAA;
      repeat (3) @(negedge CLK);
      check("idle_valid_ignored", {in_ready[0], busy[0]}, 0);
      in_valid[0] = 1'b0;

      run_load(0, 32'hA53C_FFE0, 0, 0, 0, 0, "basic");
      run_load(0, 32'hA53C_FFE0, 2, 5, 0, 0, "gap5");
      run_load(0, 32'hA53C_FFE0, 0, 7, 0, 0, "stall_first");
      run_load(0, 32'hA53C_FFE0, 2, 30, 0, 0, "stall_mid");
      run_load(0, 32'hA53C_FFE0, 0, 0, 20, 0, "restart_ignored");
      run_load(0, 32'hA53C_FFE0, 0, 0, 0, 10, "reset_mid");
      run_load(0, 32'hA53C_FFE0, 0, 0, 0, 0, "after_reset");
      run_load(1, 32'h8000_0000, 0, 0, 0, 0, "div5");
      run_load(1, 32'h0100_0000, 0, 0, 0, 0, "crc01");
      for (int i = 0; i < 4; i++)
         run_load(0, $urandom(), $urandom_range(0, 3), $urandom_range(0, 12), 0, 0, "rand_u0");
      for (int i = 0; i < 2; i++)
         run_load(1, $urandom(), 0, $urandom_range(0, 6), 0, 0, "rand_u1");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
